// File: rtl/obi_bus_responder.sv
// obi_bus_responder: legal-by-construction OBI responder for a formal harness.
// Each channel turns free solver inputs (gnt_rand_i, rvalid_rand_i, rdata_rand_i)
// into protocol-correct gnt/rvalid/rdata. It tracks outstanding transactions,
// optionally forces bounded grant/response latency, and flags requesters that
// change or drop a request before it is granted.
module obi_bus_responder #(
    parameter  int N_CH            = 2,
    parameter  int ADDR_W          = 32,
    parameter  int DATA_W          = 32,
    parameter  int MAX_OUTSTANDING = 2,
    parameter  int MAX_GNT_WAIT    = 3,
    parameter  int MAX_RVALID_WAIT = 3,
    parameter  int FAIRNESS        = 1,
    localparam int BE_W            = DATA_W / 8,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_CH-1:0]          req_i,
    input  logic [N_CH*ADDR_W-1:0]   addr_i,
    input  logic [N_CH-1:0]          we_i,
    input  logic [N_CH*BE_W-1:0]     be_i,
    input  logic [N_CH*DATA_W-1:0]   wdata_i,
    input  logic [N_CH-1:0]          gnt_rand_i,
    input  logic [N_CH-1:0]          rvalid_rand_i,
    input  logic [N_CH*DATA_W-1:0]   rdata_rand_i,
    output logic [N_CH-1:0]          gnt_o,
    output logic [N_CH-1:0]          rvalid_o,
    output logic [N_CH*DATA_W-1:0]   rdata_o,
    output logic [N_CH*CNT_W-1:0]    outstanding_o,
    output logic [N_CH-1:0]          proto_err_o
);

    // Wait counters need to hold 0..MAX inclusive; keep at least one bit so a
    // zero bound still yields a legal vector.
    localparam int GW_W = (MAX_GNT_WAIT    > 0) ? $clog2(MAX_GNT_WAIT + 1)    : 1;
    localparam int RW_W = (MAX_RVALID_WAIT > 0) ? $clog2(MAX_RVALID_WAIT + 1) : 1;

    localparam logic [CNT_W-1:0] OUT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [GW_W-1:0]  GW_MAX  = GW_W'(MAX_GNT_WAIT);
    localparam logic [RW_W-1:0]  RW_MAX  = RW_W'(MAX_RVALID_WAIT);
    localparam logic             FAIR_EN = (FAIRNESS != 0);

    typedef enum logic {
        REQ_IDLE,
        REQ_PENDING
    } req_state_e;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch

        // Current request fields of this channel.
        logic [ADDR_W-1:0] addr_cur;
        logic              we_cur;
        logic [BE_W-1:0]   be_cur;
        logic [DATA_W-1:0] wdata_cur;

        // Captured request while it waits for its grant.
        logic [ADDR_W-1:0] addr_cap;
        logic              we_cap;
        logic [BE_W-1:0]   be_cap;
        logic [DATA_W-1:0] wdata_cap;

        req_state_e        state_q, state_d;
        logic [CNT_W-1:0]  outstanding_q, outstanding_d;
        logic [GW_W-1:0]   gnt_wait_q, gnt_wait_d;
        logic [RW_W-1:0]   rv_wait_q, rv_wait_d;
        logic              err_q, err_d;
        logic              capture_en;
        logic              gnt;
        logic              rvalid;

        assign addr_cur  = addr_i[c*ADDR_W +: ADDR_W];
        assign we_cur    = we_i[c];
        assign be_cur    = be_i[c*BE_W +: BE_W];
        assign wdata_cur = wdata_i[c*DATA_W +: DATA_W];

        // Response decisions, request FSM next state, counters and checker.
        always_comb begin
            // NOTE: every signal gets a default first so no path leaves it
            // unassigned; otherwise synthesis infers a latch.
            gnt           = 1'b0;
            rvalid        = 1'b0;
            state_d       = state_q;
            capture_en    = 1'b0;
            err_d         = err_q;
            outstanding_d = outstanding_q;
            gnt_wait_d    = '0;
            rv_wait_d     = '0;

            // Grant only a live request with room left; fairness may force it.
            gnt = !reset && req_i[c] && (outstanding_q < OUT_MAX) &&
                  (gnt_rand_i[c] || (FAIR_EN && gnt_wait_q == GW_MAX));

            // Respond only when something is outstanding; fairness may force it.
            rvalid = !reset && (outstanding_q != '0) &&
                     (rvalid_rand_i[c] || (FAIR_EN && rv_wait_q == RW_MAX));

            outstanding_d = outstanding_q + CNT_W'(gnt) - CNT_W'(rvalid);

            if (req_i[c] && !gnt) begin
                gnt_wait_d = (gnt_wait_q == GW_MAX) ? gnt_wait_q : gnt_wait_q + 1'b1;
            end

            if ((outstanding_q != '0) && !rvalid) begin
                rv_wait_d = (rv_wait_q == RW_MAX) ? rv_wait_q : rv_wait_q + 1'b1;
            end

            case (state_q)
                REQ_IDLE: begin
                    if (req_i[c] && !gnt) begin
                        state_d    = REQ_PENDING;
                        capture_en = 1'b1;
                    end
                end
                REQ_PENDING: begin
                    // A stalled request must stay asserted and unchanged.
                    if (!req_i[c] || addr_cur != addr_cap || we_cur != we_cap ||
                        be_cur != be_cap || wdata_cur != wdata_cap) begin
                        err_d = 1'b1;
                    end
                    if (gnt) begin
                        state_d = REQ_IDLE;
                    end
                end
                default: state_d = REQ_IDLE;
            endcase
        end

        // Channel state registers; reset drops any in-flight transaction.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                state_q       <= REQ_IDLE;
                outstanding_q <= '0;
                gnt_wait_q    <= '0;
                rv_wait_q     <= '0;
                err_q         <= 1'b0;
            end else begin
                // NOTE: sequential state uses non-blocking assignments so all
                // registers update together from pre-edge values.
                state_q       <= state_d;
                outstanding_q <= outstanding_d;
                gnt_wait_q    <= gnt_wait_d;
                rv_wait_q     <= rv_wait_d;
                err_q         <= err_d;
            end
        end

        // Capture the request fields when a request starts to stall.
        always_ff @(posedge clock or posedge reset) begin
            // NOTE: the capture registers are reset too, so a stale request from
            // before reset can never be compared against after it.
            if (reset) begin
                addr_cap  <= '0;
                we_cap    <= 1'b0;
                be_cap    <= '0;
                wdata_cap <= '0;
            end else if (capture_en) begin
                addr_cap  <= addr_cur;
                we_cap    <= we_cur;
                be_cap    <= be_cur;
                wdata_cap <= wdata_cur;
            end
        end

        assign gnt_o[c]                          = gnt;
        assign rvalid_o[c]                       = rvalid;
        assign rdata_o[c*DATA_W +: DATA_W]       = rvalid ? rdata_rand_i[c*DATA_W +: DATA_W] : '0;
        assign outstanding_o[c*CNT_W +: CNT_W]   = outstanding_q;
        assign proto_err_o[c]                    = err_q;
    end

endmodule

// File: tb/tb_obi_bus_responder.sv
// Testbench for obi_bus_responder: one fair and one random-only instance share
// the same stimulus and are compared every cycle against a behavioural model.
module tb_obi_bus_responder;

    localparam int N_CH    = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int BE_W    = DATA_W / 8;
    localparam int MAX_OUT = 2;
    localparam int MAX_GW  = 3;
    localparam int MAX_RW  = 3;
    localparam int CNT_W   = $clog2(MAX_OUT + 1);
    localparam int N_INST  = 2;  // instance 0: FAIRNESS=1, instance 1: FAIRNESS=0

    logic                   clock;
    logic                   reset;
    logic [N_CH-1:0]        req;
    logic [N_CH*ADDR_W-1:0] addr;
    logic [N_CH-1:0]        we;
    logic [N_CH*BE_W-1:0]   be;
    logic [N_CH*DATA_W-1:0] wdata;
    logic [N_CH-1:0]        gnt_rand;
    logic [N_CH-1:0]        rvalid_rand;
    logic [N_CH*DATA_W-1:0] rdata_rand;

    logic [N_CH-1:0]        gnt_s    [N_INST];
    logic [N_CH-1:0]        rvalid_s [N_INST];
    logic [N_CH*DATA_W-1:0] rdata_s  [N_INST];
    logic [N_CH*CNT_W-1:0]  out_s    [N_INST];
    logic [N_CH-1:0]        err_s    [N_INST];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, per instance and channel.
    int                m_out  [N_INST][N_CH];
    int                m_gw   [N_INST][N_CH];
    int                m_rw   [N_INST][N_CH];
    bit                m_pend [N_INST][N_CH];
    bit                m_err  [N_INST][N_CH];
    logic [ADDR_W-1:0] m_addr [N_INST][N_CH];
    logic              m_we   [N_INST][N_CH];
    logic [BE_W-1:0]   m_be   [N_INST][N_CH];
    logic [DATA_W-1:0] m_wdata[N_INST][N_CH];

    obi_bus_responder #(
        .N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(MAX_OUT),
        .MAX_GNT_WAIT(MAX_GW), .MAX_RVALID_WAIT(MAX_RW), .FAIRNESS(1)
    ) dut_fair (
        .clock(clock), .reset(reset), .req_i(req), .addr_i(addr), .we_i(we),
        .be_i(be), .wdata_i(wdata), .gnt_rand_i(gnt_rand), .rvalid_rand_i(rvalid_rand),
        .rdata_rand_i(rdata_rand), .gnt_o(gnt_s[0]), .rvalid_o(rvalid_s[0]),
        .rdata_o(rdata_s[0]), .outstanding_o(out_s[0]), .proto_err_o(err_s[0])
    );

    obi_bus_responder #(
        .N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(MAX_OUT),
        .MAX_GNT_WAIT(MAX_GW), .MAX_RVALID_WAIT(MAX_RW), .FAIRNESS(0)
    ) dut_rand (
        .clock(clock), .reset(reset), .req_i(req), .addr_i(addr), .we_i(we),
        .be_i(be), .wdata_i(wdata), .gnt_rand_i(gnt_rand), .rvalid_rand_i(rvalid_rand),
        .rdata_rand_i(rdata_rand), .gnt_o(gnt_s[1]), .rvalid_o(rvalid_s[1]),
        .rdata_o(rdata_s[1]), .outstanding_o(out_s[1]), .proto_err_o(err_s[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_INST; i++) begin
            for (int c = 0; c < N_CH; c++) begin
                m_out[i][c] = 0;  m_gw[i][c] = 0;  m_rw[i][c] = 0;
                m_pend[i][c] = 0; m_err[i][c] = 0;
                m_addr[i][c] = '0; m_we[i][c] = 1'b0; m_be[i][c] = '0; m_wdata[i][c] = '0;
            end
        end
    endtask

    // Compare every output against the model, advance the model, then move on
    // to the next cycle's drive point (negedge).
    task automatic step();
        #1;
        for (int i = 0; i < N_INST; i++) begin
            for (int c = 0; c < N_CH; c++) begin
                bit fair;
                bit e_gnt;
                bit e_rv;
                bit changed;
                logic [DATA_W-1:0] e_rdata;
                fair  = (i == 0);
                e_gnt = req[c] && (m_out[i][c] < MAX_OUT) &&
                        (gnt_rand[c] || (fair && m_gw[i][c] == MAX_GW));
                e_rv  = (m_out[i][c] > 0) &&
                        (rvalid_rand[c] || (fair && m_rw[i][c] == MAX_RW));
                e_rdata = e_rv ? rdata_rand[c*DATA_W +: DATA_W] : '0;

                check($sformatf("gnt_i%0d_c%0d", i, c), gnt_s[i][c], e_gnt);
                check($sformatf("rvalid_i%0d_c%0d", i, c), rvalid_s[i][c], e_rv);
                check($sformatf("rdata_i%0d_c%0d", i, c), rdata_s[i][c*DATA_W +: DATA_W], e_rdata);
                check($sformatf("outstanding_i%0d_c%0d", i, c), out_s[i][c*CNT_W +: CNT_W], m_out[i][c]);
                check($sformatf("proto_err_i%0d_c%0d", i, c), err_s[i][c], m_err[i][c]);

                changed = (addr[c*ADDR_W +: ADDR_W] != m_addr[i][c]) || (we[c] != m_we[i][c]) ||
                          (be[c*BE_W +: BE_W] != m_be[i][c]) ||
                          (wdata[c*DATA_W +: DATA_W] != m_wdata[i][c]);
                if (m_pend[i][c] && (!req[c] || changed)) m_err[i][c] = 1;

                if (!m_pend[i][c] && req[c] && !e_gnt) begin
                    m_pend[i][c]  = 1;
                    m_addr[i][c]  = addr[c*ADDR_W +: ADDR_W];
                    m_we[i][c]    = we[c];
                    m_be[i][c]    = be[c*BE_W +: BE_W];
                    m_wdata[i][c] = wdata[c*DATA_W +: DATA_W];
                end else if (m_pend[i][c] && e_gnt) begin
                    m_pend[i][c] = 0;
                end

                m_gw[i][c] = (req[c] && !e_gnt) ? ((m_gw[i][c] < MAX_GW) ? m_gw[i][c] + 1 : MAX_GW) : 0;
                m_rw[i][c] = (m_out[i][c] > 0 && !e_rv) ? ((m_rw[i][c] < MAX_RW) ? m_rw[i][c] + 1 : MAX_RW) : 0;
                m_out[i][c] = m_out[i][c] + int'(e_gnt) - int'(e_rv);
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input int c, input bit r, input logic [ADDR_W-1:0] a,
                         input bit gr, input bit rr, input logic [DATA_W-1:0] rd);
        req[c]                       = r;
        addr[c*ADDR_W +: ADDR_W]     = a;
        gnt_rand[c]                  = gr;
        rvalid_rand[c]               = rr;
        rdata_rand[c*DATA_W +: DATA_W] = rd;
    endtask

    task automatic check_reset_outputs(input string tag);
        #1;
        for (int i = 0; i < N_INST; i++) begin
            check($sformatf("%s_gnt_i%0d", tag, i), gnt_s[i], '0);
            check($sformatf("%s_rvalid_i%0d", tag, i), rvalid_s[i], '0);
            check($sformatf("%s_out_i%0d", tag, i), out_s[i], '0);
        end
    endtask

    initial begin
        reset = 1'b1;
        req = '1; gnt_rand = '1; rvalid_rand = '1;
        addr = '0; we = '0; be = '0; wdata = '0; rdata_rand = '0;
        model_reset();

        // Reset holds grant and response low even with request and grant choice high.
        check_reset_outputs("reset_hold");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        req = '0; gnt_rand = '0; rvalid_rand = '0;
        #1;
        check("reset_out_after", out_s[0], '0);
        check("reset_err_after", err_s[0], '0);
        step();

        // Basic read on ch0: zero-latency grant, response one cycle later.
        drive(0, 1, 32'h40, 1, 0, '0);
        #1;
        check("basic_gnt", gnt_s[0][0], 1'b1);
        step();
        drive(0, 0, 32'h40, 0, 1, 32'hDEADBEEF);
        #1;
        check("basic_rvalid", rvalid_s[0][0], 1'b1);
        check("basic_rdata", rdata_s[0][DATA_W-1:0], 32'hDEADBEEF);
        step();
        drive(0, 0, 32'h40, 0, 0, '0);
        #1;
        check("basic_out_zero", out_s[0][CNT_W-1:0], '0);
        step();

        // Fairness: forced grant on 4th cycle, forced response 4 cycles later.
        drive(0, 1, 32'h80, 0, 0, '0);
        for (int k = 1; k <= 4; k++) begin
            #1;
            check($sformatf("fair_gnt_k%0d", k), gnt_s[0][0], (k == 4));
            step();
            if (k == 4) req[0] = 1'b0;
        end
        rdata_rand[DATA_W-1:0] = 32'h1234_5678;
        for (int k = 1; k <= 4; k++) begin
            #1;
            check($sformatf("fair_rvalid_k%0d", k), rvalid_s[0][0], (k == 4));
            step();
        end

        // Full: two grants fill the channel; third waits until after a response.
        drive(0, 1, 32'h200, 1, 0, '0);
        step();
        drive(0, 1, 32'h204, 1, 0, '0);
        step();
        drive(0, 1, 32'h208, 1, 0, '0);
        #1;
        check("full_out_two", out_s[0][CNT_W-1:0], 2'd2);
        check("full_no_gnt", gnt_s[0][0], 1'b0);
        step();
        rvalid_rand[0] = 1'b1;
        #1;
        check("full_rvalid", rvalid_s[0][0], 1'b1);
        check("full_no_gnt_on_rvalid", gnt_s[0][0], 1'b0);
        step();
        rvalid_rand[0] = 1'b0;
        #1;
        check("full_gnt_after", gnt_s[0][0], 1'b1);
        step();
        drive(0, 0, 32'h208, 0, 1, 32'hCAFE_F00D);
        repeat (3) step();
        #1;
        check("full_drained", out_s[0][CNT_W-1:0], '0);

        // Simultaneous grant and response keep the count unchanged.
        drive(0, 1, 32'h300, 1, 0, '0);
        step();
        drive(0, 1, 32'h304, 1, 1, 32'hA5A5_5A5A);
        #1;
        check("simul_gnt", gnt_s[0][0], 1'b1);
        check("simul_rvalid", rvalid_s[0][0], 1'b1);
        step();
        drive(0, 0, 32'h304, 0, 0, '0);
        #1;
        check("simul_out_one", out_s[0][CNT_W-1:0], 2'd1);
        rvalid_rand[0] = 1'b1;
        repeat (2) step();

        // Protocol: address changes while stalled; flag is sticky, ch1 unaffected.
        drive(0, 1, 32'h100, 0, 0, '0);
        step();
        addr[ADDR_W-1:0] = 32'h104;
        #1;
        check("proto_err_before", err_s[0][0], 1'b0);
        step();
        #1;
        check("proto_err_set", err_s[0][0], 1'b1);
        check("proto_err_other_ch", err_s[0][1], 1'b0);
        req[0] = 1'b0;
        repeat (2) step();
        #1;
        check("proto_err_sticky", err_s[0][0], 1'b1);

        // Reset mid-flight with an outstanding transaction drops it.
        drive(0, 1, 32'h104, 1, 0, '0);
        step();
        reset = 1'b1;
        model_reset();
        check_reset_outputs("reset_mid");
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        drive(0, 0, 32'h0, 0, 0, '0);
        #1;
        check("reset_mid_err_clear", err_s[0][0], 1'b0);
        step();

        // Randomized traffic; the requester keeps a stalled request stable for
        // the fair instance, and the random-only instance is also checked for
        // the basic legality invariants.
        for (int n = 0; n < 2000; n++) begin
            for (int c = 0; c < N_CH; c++) begin
                if (!m_pend[0][c]) begin
                    req[c]                         = ($urandom_range(0, 9) < 6);
                    addr[c*ADDR_W +: ADDR_W]       = $urandom;
                    we[c]                          = $urandom_range(0, 1);
                    be[c*BE_W +: BE_W]             = BE_W'($urandom);
                    wdata[c*DATA_W +: DATA_W]      = $urandom;
                end
                gnt_rand[c]                    = ($urandom_range(0, 3) == 0);
                rvalid_rand[c]                 = ($urandom_range(0, 2) == 0);
                rdata_rand[c*DATA_W +: DATA_W] = $urandom;
            end
            #1;
            for (int c = 0; c < N_CH; c++) begin
                check("rand_gnt_needs_req", gnt_s[1][c] & ~req[c], 1'b0);
                check("rand_rvalid_needs_out",
                      rvalid_s[1][c] & (out_s[1][c*CNT_W +: CNT_W] == '0), 1'b0);
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
